// File: rtl/fp8_e4m3_pkg.sv
// Shared E4M3 constants, pipeline payload types and the unpack/finalize helpers
// used by the FP32 -> FP8 E4M3 converter.
package fp8_e4m3_pkg;

  localparam int FP8_EXP_W   = 4;
  localparam int FP8_MANT_W  = 3;
  localparam int FP8_W       = 1 + FP8_EXP_W + FP8_MANT_W;
  localparam int FP8_BIAS    = 7;
  localparam int FP32_BIAS   = 127;
  localparam int FP8_EXP_MAX = 15;
  localparam logic [6:0] FP8_MAX_MAG = 7'h7F;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  localparam int EXP_W = 10;
  localparam int SIG_W = 24;

  typedef enum logic [2:0] {
    CLS_NORMAL    = 3'd0,
    CLS_ZERO      = 3'd1,
    CLS_SUBNORMAL = 3'd2,
    CLS_INF       = 3'd3,
    CLS_NAN       = 3'd4
  } fp32_class_e;

  typedef struct packed {
    logic                    sign;
    fp32_class_e             cls;
    logic signed [EXP_W-1:0] exp8;
    logic [SIG_W-1:0]        sig;
  } unpacked_t;

  typedef struct packed {
    logic              sign;
    fp32_class_e       cls;
    logic [FP8_W-1:0]  data;
    logic [FLAG_W-1:0] flags;
  } rounded_t;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [FP8_W-1:0]  data;
  } result_t;

  // Rebias straight into the FP8 exponent domain so the rounder sees e8 directly.
  function automatic unpacked_t fp32_unpack(input logic [31:0] x);
    unpacked_t u;
    u.sign = x[31];
    u.exp8 = $signed({2'b00, x[30:23]}) - $signed(EXP_W'(FP32_BIAS - FP8_BIAS));
    u.sig  = {1'b1, x[22:0]};
    if (&x[30:23])       u.cls = (~|x[22:0]) ? CLS_INF : CLS_NAN;
    else if (~|x[30:23]) u.cls = (~|x[22:0]) ? CLS_ZERO : CLS_SUBNORMAL;
    else                 u.cls = CLS_NORMAL;
    return u;
  endfunction

  function automatic result_t fp8_finalize(input rounded_t r);
    result_t res;
    res.flags = r.flags;
    res.data  = r.data;
    case (r.cls)
      CLS_ZERO: begin
        res.flags = '0;
        res.data  = '0;
      end
      CLS_SUBNORMAL: begin
        res.flags               = '0;
        res.flags[FLAG_INEXACT] = 1'b1;
        res.data                = '0;
      end
      CLS_INF: begin
        res.flags                = '0;
        res.flags[FLAG_OVERFLOW] = 1'b1;
        res.data                 = {r.sign, FP8_MAX_MAG};
      end
      CLS_NAN: begin
        res.flags               = '0;
        res.flags[FLAG_INVALID] = 1'b1;
        res.data                = {1'b0, FP8_MAX_MAG};
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fp32_to_fp8_e4m3_if.sv
// Operand/result stream bundle. Handshake: a beat moves on a rising edge where
// valid && ready; a producer holding valid keeps its payload stable until taken.
interface fp32_to_fp8_e4m3_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp8_e4m3_round.sv
// Combinational align/round/saturate of a finite operand already rebiased to
// the FP8 exponent (e8); emits the packed E4M3 byte and its flags.
module fp8_e4m3_round
  import fp8_e4m3_pkg::*;
(
  input  logic                    i_sign,
  input  logic signed [EXP_W-1:0] i_exp,
  input  logic [SIG_W-1:0]        i_sig,
  input  logic                    i_rne,
  output logic [FP8_W-1:0]        o_data,
  output logic [FLAG_W-1:0]       o_flags
);

  localparam int L_MSB = SIG_W - 1;
  localparam int L_LSB = SIG_W - 1 - FP8_MANT_W;
  localparam int L_G   = L_LSB - 1;

  logic                    w_sub;
  logic signed [EXP_W-1:0] w_sh_full;
  logic [2:0]              w_sh;
  logic [SIG_W+4:0]        w_wide;
  logic [SIG_W-1:0]        w_shifted;
  logic                    w_guard;
  logic                    w_sticky;
  logic                    w_rnd;
  logic [FP8_MANT_W+1:0]   w_sum;
  logic signed [EXP_W-1:0] w_exp_rnd;
  logic                    w_lost;
  logic                    w_sat;
  logic                    w_zero;

  always_comb begin
    w_sub     = i_exp[EXP_W-1] | ~|i_exp;
    w_sh_full = 10'sd1 - i_exp;
    // Five places already push the hidden bit below guard, so larger shifts are all sticky.
    if (!w_sub)                   w_sh = 3'd0;
    else if (w_sh_full > 10'sd5)  w_sh = 3'd5;
    else                          w_sh = w_sh_full[2:0];

    w_wide    = {i_sig, 5'b00000} >> w_sh;
    w_shifted = w_wide[SIG_W+4:5];
    w_guard   = w_shifted[L_G];
    w_sticky  = (|w_shifted[L_G-1:0]) | (|w_wide[4:0]);
    w_rnd     = i_rne & w_guard & (w_sticky | w_shifted[L_LSB]);
    w_sum     = {1'b0, w_shifted[L_MSB:L_LSB]} + {{FP8_MANT_W+1{1'b0}}, w_rnd};

    // Subnormal carry into bit 3 lands on the smallest normal (exp 1, mant 0).
    if (w_sub) w_exp_rnd = $signed({{EXP_W-1{1'b0}}, w_sum[FP8_MANT_W]});
    else       w_exp_rnd = i_exp + $signed({{EXP_W-1{1'b0}}, w_sum[FP8_MANT_W+1]});

    w_lost = w_guard | w_sticky;
    w_sat  = (w_exp_rnd > 10'sd15);
    w_zero = ~|w_exp_rnd[FP8_EXP_W-1:0] & ~|w_sum[FP8_MANT_W-1:0];

    o_flags = '0;
    o_data  = {i_sign, w_exp_rnd[FP8_EXP_W-1:0], w_sum[FP8_MANT_W-1:0]};
    if (w_sat) begin
      o_data                 = {i_sign, FP8_MAX_MAG};
      o_flags[FLAG_OVERFLOW] = 1'b1;
      o_flags[FLAG_INEXACT]  = 1'b1;
    end else begin
      if (w_zero) o_data = '0;
      o_flags[FLAG_INEXACT]   = w_lost;
      o_flags[FLAG_UNDERFLOW] = w_sub & w_lost;
    end
  end

endmodule

// File: rtl/fp32_to_fp8_e4m3.sv
// Three-stage FP32 -> FP8 E4M3 converter: S1 unpack/classify, S2 align/round,
// S3 pack/saturate. Each stage loads when its successor is empty or draining.
module fp32_to_fp8_e4m3
  import fp8_e4m3_pkg::*;
#(
  parameter bit RNE = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  fp32_to_fp8_e4m3_if.slave  bus
);

  logic              r_v1;
  logic              r_v2;
  logic              r_v3;
  unpacked_t         r_s1;
  rounded_t          r_s2;
  result_t           r_s3;

  logic              w_s3_free;
  logic              w_s2_free;
  logic              w_s2_adv;
  logic              w_s1_free;
  logic              w_s1_adv;
  logic              w_accept;
  logic [FP8_W-1:0]  w_rnd_data;
  logic [FLAG_W-1:0] w_rnd_flags;

  always_comb begin
    w_s3_free = ~r_v3 | bus.out_ready;
    w_s2_adv  = r_v2 & w_s3_free;
    w_s2_free = ~r_v2 | w_s3_free;
    w_s1_adv  = r_v1 & w_s2_free;
    w_s1_free = ~r_v1 | w_s2_free;
    w_accept  = bus.in_valid & bus.in_ready;
  end

  // Gating with rst_n keeps the input closed while reset is held.
  assign bus.in_ready  = rst_n & w_s1_free;
  assign bus.out_valid = r_v3;
  assign bus.out_data  = r_s3.data;
  assign bus.out_flags = r_s3.flags;

  fp8_e4m3_round u_round (
    .i_sign  (r_s1.sign),
    .i_exp   (r_s1.exp8),
    .i_sig   (r_s1.sig),
    .i_rne   (RNE),
    .o_data  (w_rnd_data),
    .o_flags (w_rnd_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_s3 <= '0;
    end else begin
      if (w_s1_free) r_v1 <= w_accept;
      if (w_s2_free) r_v2 <= r_v1;
      if (w_s3_free) r_v3 <= r_v2;
      if (w_s2_adv)  r_s3 <= fp8_finalize(r_s2);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_s1 <= fp32_unpack(bus.in_data);
    if (w_s1_adv) begin
      r_s2.sign  <= r_s1.sign;
      r_s2.cls   <= r_s1.cls;
      r_s2.data  <= w_rnd_data;
      r_s2.flags <= w_rnd_flags;
    end
  end

endmodule

// File: tb/tb_fp32_to_fp8_e4m3.sv
// Bench for fp32_to_fp8_e4m3: directed vectors, backpressure, reset flush and
// randomized operands against a real-valued nearest-code reference model.
module tb_fp32_to_fp8_e4m3;

  localparam bit RNE_P = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  fp32_to_fp8_e4m3_if bus ();

  fp32_to_fp8_e4m3 #(.RNE(RNE_P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required completion");
    $fatal(1, "watchdog timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];
  logic [31:0] in_q[$];
  int          acc_q[$];
  logic        lat_chk = 1'b0;
  logic        held = 1'b0;
  logic        seen = 1'b0;
  logic [11:0] held_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic real fp8_mag(input int k);
    int e;
    int m;
    e = k / 8;
    m = k % 8;
    if (e == 0) return (real'(m) / 8.0) * (2.0 ** -6.0);
    return (1.0 + real'(m) / 8.0) * (2.0 ** real'(e - 7));
  endfunction

  // Returns {flags, data}; flags = {invalid, overflow, underflow, inexact}.
  function automatic logic [11:0] ref_model(input logic [31:0] x);
    logic s;
    int   e;
    int   f;
    real  mag;
    real  mid;
    int   lo;
    int   pick;
    logic inexact;
    logic under;
    s = x[31];
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    if (e == 255) return (f == 0) ? {4'b0100, s, 7'h7F} : {4'b1000, 8'h7F};
    if (e == 0)   return (f == 0) ? 12'h000 : {4'b0001, 8'h00};
    mag = real'(f + 8388608) * (2.0 ** real'(e - 150));
    if (mag >= 512.0) return {4'b0101, s, 7'h7F};
    lo = 0;
    for (int k = 1; k < 128; k++) if (fp8_mag(k) <= mag) lo = k;
    inexact = (fp8_mag(lo) != mag);
    pick = lo;
    if (inexact && RNE_P) begin
      mid = (fp8_mag(lo) + fp8_mag(lo + 1)) / 2.0;
      if (mag > mid) pick = lo + 1;
      else if (mag == mid && (lo % 2) == 1) pick = lo + 1;
    end
    if (pick == 128) return {4'b0101, s, 7'h7F};
    under = inexact && (mag < (2.0 ** -6.0));
    if (pick == 0) return {2'b00, under, inexact, 8'h00};
    return {2'b00, under, inexact, s, 7'(pick)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] d, input logic [11:0] req);
    int t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(req);
    in_q.push_back(d);
    acc_q.push_back(cyc);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    int          sel;
    x   = $urandom();
    sel = $urandom_range(0, 9);
    if (sel <= 6) x[30:23] = 8'($urandom_range(108, 137));
    else if (sel == 7) begin
      x[30:23] = 8'($urandom_range(112, 136));
      x[18:0]  = '0;
    end else if (sel == 9) begin
      x[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 2) == 0) x[22:0] = '0;
    end
    return x;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
        seen = 1'b0;
      end else if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_with_nothing_pending", 32'(bus.out_valid), 32'd0);
        end else begin
          if (held) check("hold_stable", 32'({bus.out_flags, bus.out_data}), 32'(held_val));
          if (!seen && lat_chk) check("latency", 32'(cyc - acc_q[0]), 32'd3);
          seen = 1'b1;
          if (bus.out_ready) begin
            check($sformatf("data[in=%h]", in_q[0]), 32'(bus.out_data), 32'(exp_q[0][7:0]));
            check($sformatf("flags[in=%h]", in_q[0]), 32'(bus.out_flags), 32'(exp_q[0][11:8]));
            void'(exp_q.pop_front());
            void'(in_q.pop_front());
            void'(acc_q.pop_front());
            held = 1'b0;
            seen = 1'b0;
          end else begin
            held     = 1'b1;
            held_val = {bus.out_flags, bus.out_data};
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [43:0] dir_tab[$];
  logic [31:0] bp_vec[5];
  logic        rnd_run;
  int          n_acc;
  int          stale;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // {operand, flags, data}
    dir_tab.push_back({32'h3F800000, 4'h0, 8'h38});
    dir_tab.push_back({32'hC0000000, 4'h0, 8'hC0});
    dir_tab.push_back({32'h3F880000, 4'h1, 8'h38});
    dir_tab.push_back({32'h3F980000, 4'h1, 8'h3A});
    dir_tab.push_back({32'h3F900000, 4'h0, 8'h39});
    dir_tab.push_back({32'h43F00000, 4'h0, 8'h7F});
    dir_tab.push_back({32'h43F40000, 4'h1, 8'h7F});
    dir_tab.push_back({32'h43F80000, 4'h5, 8'h7F});
    dir_tab.push_back({32'hC4800000, 4'h5, 8'hFF});
    dir_tab.push_back({32'h3B800000, 4'h0, 8'h02});
    dir_tab.push_back({32'h3B000000, 4'h0, 8'h01});
    dir_tab.push_back({32'h3A800000, 4'h3, 8'h00});
    dir_tab.push_back({32'h3AC00000, 4'h3, 8'h01});
    dir_tab.push_back({32'h3A000000, 4'h3, 8'h00});
    dir_tab.push_back({32'hBA000000, 4'h3, 8'h00});
    dir_tab.push_back({32'h3C7C0000, 4'h3, 8'h08});
    dir_tab.push_back({32'h7FC00000, 4'h8, 8'h7F});
    dir_tab.push_back({32'hFFC00001, 4'h8, 8'h7F});
    dir_tab.push_back({32'hFF800000, 4'h4, 8'hFF});
    dir_tab.push_back({32'h7F800000, 4'h4, 8'h7F});
    dir_tab.push_back({32'h00000001, 4'h1, 8'h00});
    dir_tab.push_back({32'h00000000, 4'h0, 8'h00});
    dir_tab.push_back({32'h80000000, 4'h0, 8'h00});

    // asynchronous reset, no clock edge involved
    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'h00);
    check("reset_out_flags", 32'(bus.out_flags), 32'h0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // directed vectors, back-to-back, out_ready held high
    lat_chk = 1'b1;
    foreach (dir_tab[i]) send(dir_tab[i][43:12], dir_tab[i][11:0]);
    idle();
    drain();

    // backpressure: 5 operands offered with out_ready low for 6 cycles
    lat_chk = 1'b0;
    bp_vec = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h3E000000, 32'h3F980000};
    n_acc = 0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = bp_vec[n_acc];
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(ref_model(bp_vec[n_acc]));
        in_q.push_back(bp_vec[n_acc]);
        acc_q.push_back(cyc);
        n_acc++;
      end
    end
    check("bp_accepts_before_stall", 32'(n_acc), 32'd3);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int i = 3; i < 5; i++) send(bp_vec[i], ref_model(bp_vec[i]));
    idle();
    drain();

    // reset with two operands in flight
    lat_chk = 1'b1;
    send(32'h3F800000, 12'h038);
    send(32'h40400000, ref_model(32'h40400000));
    idle();
    @(posedge clk);
    #1;
    check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    in_q.delete();
    acc_q.delete();
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_out_data", 32'(bus.out_data), 32'h00);
    check("flush_out_flags", 32'(bus.out_flags), 32'h0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #2;
      if (bus.out_valid) stale++;
    end
    check("no_stale_output", 32'(stale), 32'd0);
    send(32'h3F980000, 12'h13A);
    idle();
    drain();

    // randomized operands with random backpressure
    lat_chk = 1'b0;
    rnd_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          logic [31:0] x;
          if ($urandom_range(0, 3) == 0) idle();
          x = rand_operand();
          send(x, ref_model(x));
        end
        idle();
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
